// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: merges register-file writes from the writeback stage
// (requester 0) and the multi-cycle mult/div unit (requester 1) onto the
// single register-file write port. Each requester owns a one-entry buffer.
// When both buffers are occupied, the requester that did not win the
// previous collision wins. Writes to register 0 are drained without
// asserting the write strobe.
module rf_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_index,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_index,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              writeEnable,
    output logic [ADDR_W-1:0] index,
    output logic [DATA_W-1:0] valueInput,
    output logic              grant_id,
    output logic              collide
);

    // Requester buffers.
    logic              full0_q, full1_q;
    logic [ADDR_W-1:0] idx0_q, idx1_q;
    logic [DATA_W-1:0] dat0_q, dat1_q;

    // Arbitration history: identity of the winner of the last collision.
    logic              last_grant_q;

    // Registered write-port outputs.
    logic              we_q;
    logic [ADDR_W-1:0] index_q;
    logic [DATA_W-1:0] value_q;
    logic              gid_q;
    logic              collide_q;

    // Combinational arbitration and buffer next-state.
    logic              both_s;
    logic              gnt_any_s;
    logic              gnt_id_s;
    logic [ADDR_W-1:0] gnt_idx_s;
    logic [DATA_W-1:0] gnt_dat_s;
    logic              acc0_s, acc1_s;
    logic              full0_d, full1_d;

    // Pick the buffer to drain this cycle and derive buffer next-state.
    always_comb begin
        both_s    = full0_q & full1_q;
        gnt_any_s = full0_q | full1_q;
        if (both_s) begin
            gnt_id_s = ~last_grant_q;
        end else if (full1_q) begin
            gnt_id_s = 1'b1;
        end else begin
            gnt_id_s = 1'b0;
        end
        if (gnt_id_s) begin
            gnt_idx_s = idx1_q;
            gnt_dat_s = dat1_q;
        end else begin
            gnt_idx_s = idx0_q;
            gnt_dat_s = dat0_q;
        end
        // Ready is simply "buffer empty", so a buffer drained on this edge
        // cannot be refilled until the following edge.
        acc0_s = req0_valid & ~full0_q;
        acc1_s = req1_valid & ~full1_q;
        if (full0_q) begin
            full0_d = ~(gnt_any_s & ~gnt_id_s);
        end else begin
            full0_d = req0_valid;
        end
        if (full1_q) begin
            full1_d = ~(gnt_any_s & gnt_id_s);
        end else begin
            full1_d = req1_valid;
        end
    end

    // Buffer capture, arbitration history and registered write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            full0_q      <= 1'b0;
            full1_q      <= 1'b0;
            idx0_q       <= {ADDR_W{1'b0}};
            idx1_q       <= {ADDR_W{1'b0}};
            dat0_q       <= {DATA_W{1'b0}};
            dat1_q       <= {DATA_W{1'b0}};
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            index_q      <= {ADDR_W{1'b0}};
            value_q      <= {DATA_W{1'b0}};
            gid_q        <= 1'b0;
            collide_q    <= 1'b0;
        end else begin
            full0_q <= full0_d;
            full1_q <= full1_d;
            if (acc0_s) begin
                idx0_q <= req0_index;
                dat0_q <= req0_data;
            end
            if (acc1_s) begin
                idx1_q <= req1_index;
                dat1_q <= req1_data;
            end
            // Only a genuine collision moves the round-robin pointer.
            if (both_s) begin
                last_grant_q <= gnt_id_s;
            end
            collide_q <= both_s;
            // Register 0 is hard-wired to zero: drain it silently.
            we_q <= gnt_any_s && (gnt_idx_s != {ADDR_W{1'b0}});
            if (gnt_any_s) begin
                index_q <= gnt_idx_s;
                value_q <= gnt_dat_s;
                gid_q   <= gnt_id_s;
            end
        end
    end

    assign req0_ready  = ~full0_q;
    assign req1_ready  = ~full1_q;
    assign writeEnable = we_q;
    assign index       = index_q;
    assign valueInput  = value_q;
    assign grant_id    = gid_q;
    assign collide     = collide_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed vector table, a continuous-valid
// throughput scoreboard and randomized traffic against a queue-based model.
module tb_rf_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_index, req1_index;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          writeEnable;
    logic [AW-1:0] index;
    logic [DW-1:0] valueInput;
    logic          grant_id;
    logic          collide;

    rf_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_index(req0_index), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_index(req1_index), .req1_data(req1_data), .req1_ready(req1_ready),
        .writeEnable(writeEnable), .index(index), .valueInput(valueInput),
        .grant_id(grant_id), .collide(collide)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Register file driven by the DUT write port; written at the edge
    // that ends a writeEnable cycle.
    logic [DW-1:0] rf_dut [32];
    logic [DW-1:0] wr_q[$];
    initial for (int i = 0; i < 32; i++) rf_dut[i] = '0;
    always @(posedge clk) begin
        if (writeEnable === 1'b1) begin
            rf_dut[index] = valueInput;
            wr_q.push_back(valueInput);
        end
    end

    // ---------------- reference model ----------------
    typedef struct { logic [AW-1:0] idx; logic [DW-1:0] dat; } req_t;
    req_t          pq0[$], pq1[$];
    bit            m_known = 0;
    bit            m_last;
    logic          m_we, m_gid, m_col;
    logic [AW-1:0] m_idx;
    logic [DW-1:0] m_val;
    logic [DW-1:0] rf_mod [32];
    initial for (int i = 0; i < 32; i++) rf_mod[i] = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model one clock edge from the rules: a pending request is drained
    // each cycle, the non-winner of the last collision wins a collision.
    task automatic model_edge(input bit rst, input bit v0, input req_t r0, input bit v1, input req_t r1);
        bit e0, e1, w;
        req_t g;
        if (rst) begin
            pq0.delete(); pq1.delete();
            m_last = 1; m_we = 0; m_idx = '0; m_val = '0; m_gid = 0; m_col = 0;
            m_known = 1;
            return;
        end
        e0 = (pq0.size() == 0);
        e1 = (pq1.size() == 0);
        m_col = 0;
        if (!e0 || !e1) begin
            if (!e0 && !e1) begin
                w = !m_last; m_last = w; m_col = 1;
            end else begin
                w = e0;
            end
            g = w ? pq1.pop_front() : pq0.pop_front();
            m_we = (g.idx != 0); m_idx = g.idx; m_val = g.dat; m_gid = w;
            if (m_we) rf_mod[g.idx] = g.dat;
        end else begin
            m_we = 0;
        end
        if (v0 && e0) pq0.push_back(r0);
        if (v1 && e1) pq1.push_back(r1);
    endtask

    // Apply one cycle of stimulus, check against the model.
    task automatic step(input bit rst, input bit v0, input logic [AW-1:0] i0, input logic [DW-1:0] d0,
                        input bit v1, input logic [AW-1:0] i1, input logic [DW-1:0] d1);
        req_t a, b;
        reset = rst; req0_valid = v0; req0_index = i0; req0_data = d0;
        req1_valid = v1; req1_index = i1; req1_data = d1;
        a.idx = i0; a.dat = d0; b.idx = i1; b.dat = d1;
        if (m_known) begin
            chk("model_ready0_pre", 64'(req0_ready), 64'(pq0.size() == 0));
            chk("model_ready1_pre", 64'(req1_ready), 64'(pq1.size() == 0));
        end
        model_edge(rst, v0, a, v1, b);
        @(posedge clk); #1;
        chk("model_we",    64'(writeEnable), 64'(m_we));
        chk("model_index", 64'(index),       64'(m_idx));
        chk("model_value", 64'(valueInput),  64'(m_val));
        chk("model_gid",   64'(grant_id),    64'(m_gid));
        chk("model_col",   64'(collide),     64'(m_col));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit rst; bit v0; logic [AW-1:0] i0; logic [DW-1:0] d0;
        bit v1; logic [AW-1:0] i1; logic [DW-1:0] d1;
        bit we; logic [AW-1:0] idx; logic [DW-1:0] val; bit gid; bit col; bit r0; bit r1;
    } vec_t;
    vec_t tbl[19];

    function automatic vec_t mk(bit rst, bit v0, logic [AW-1:0] i0, logic [DW-1:0] d0,
                                bit v1, logic [AW-1:0] i1, logic [DW-1:0] d1,
                                bit we, logic [AW-1:0] idx, logic [DW-1:0] val,
                                bit gid, bit col, bit r0, bit r1);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.i0 = i0; v.d0 = d0; v.v1 = v1; v.i1 = i1; v.d1 = d1;
        v.we = we; v.idx = idx; v.val = val; v.gid = gid; v.col = col; v.r0 = r0; v.r1 = r1;
        return v;
    endfunction

    initial begin
        //             rst v0 i0     d0            v1 i1     d1              we idx    val            gid col r0 r1
        tbl[0]  = mk(1, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,          0, 5'd0, 32'h0,          0, 0, 1, 1);
        // single write, latency
        tbl[1]  = mk(0, 1, 5'd3, 32'h2,        0, 5'd0,  32'h0,          0, 5'd0, 32'h0,          0, 0, 0, 1);
        tbl[2]  = mk(0, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,          1, 5'd3, 32'h2,          0, 0, 1, 1);
        tbl[3]  = mk(0, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,          0, 5'd3, 32'h2,          0, 0, 1, 1);
        // simultaneous requests: collision, req0 first
        tbl[4]  = mk(0, 1, 5'd4, 32'hA,        1, 5'd5,  32'hB,          0, 5'd3, 32'h2,          0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,          1, 5'd4, 32'hA,          0, 1, 1, 0);
        tbl[6]  = mk(0, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,          1, 5'd5, 32'hB,          1, 0, 1, 1);
        tbl[7]  = mk(0, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,          0, 5'd5, 32'hB,          1, 0, 1, 1);
        // same index, next collision won by req1
        tbl[8]  = mk(0, 1, 5'd7, 32'h11,       1, 5'd7,  32'h22,         0, 5'd5, 32'hB,          1, 0, 0, 0);
        tbl[9]  = mk(0, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,          1, 5'd7, 32'h22,         1, 1, 0, 1);
        tbl[10] = mk(0, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,          1, 5'd7, 32'h11,         0, 0, 1, 1);
        tbl[11] = mk(0, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,          0, 5'd7, 32'h11,         0, 0, 1, 1);
        // write to $zero is drained silently
        tbl[12] = mk(0, 0, 5'd0, 32'h0,        1, 5'd0,  32'hFFFFFFFF,   0, 5'd7, 32'h11,         0, 0, 1, 0);
        tbl[13] = mk(0, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,          0, 5'd0, 32'hFFFFFFFF,   1, 0, 1, 1);
        tbl[14] = mk(0, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,          0, 5'd0, 32'hFFFFFFFF,   1, 0, 1, 1);
        // reset with both buffers full discards them
        tbl[15] = mk(0, 1, 5'd9, 32'h33,       1, 5'd10, 32'h44,         0, 5'd0, 32'hFFFFFFFF,   1, 0, 0, 0);
        tbl[16] = mk(1, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,          0, 5'd0, 32'h0,          0, 0, 1, 1);
        tbl[17] = mk(0, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,          0, 5'd0, 32'h0,          0, 0, 1, 1);
        tbl[18] = mk(0, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,          0, 5'd0, 32'h0,          0, 0, 1, 1);
    end

    initial begin
        int nwr, ex;
        reset = 1'b1; req0_valid = 0; req1_valid = 0;
        req0_index = '0; req1_index = '0; req0_data = '0; req1_data = '0;
        @(posedge clk); #1;

        // Directed table
        for (int r = 0; r < 19; r++) begin
            step(tbl[r].rst, tbl[r].v0, tbl[r].i0, tbl[r].d0, tbl[r].v1, tbl[r].i1, tbl[r].d1);
            chk($sformatf("tbl%0d_we", r),     64'(writeEnable), 64'(tbl[r].we));
            chk($sformatf("tbl%0d_index", r),  64'(index),       64'(tbl[r].idx));
            chk($sformatf("tbl%0d_value", r),  64'(valueInput),  64'(tbl[r].val));
            chk($sformatf("tbl%0d_gid", r),    64'(grant_id),    64'(tbl[r].gid));
            chk($sformatf("tbl%0d_col", r),    64'(collide),     64'(tbl[r].col));
            chk($sformatf("tbl%0d_ready0", r), 64'(req0_ready),  64'(tbl[r].r0));
            chk($sformatf("tbl%0d_ready1", r), 64'(req1_ready),  64'(tbl[r].r1));
        end
        chk("rf_idx7_last_grant", 64'(rf_dut[7]), 64'h11);
        chk("rf_idx3",            64'(rf_dut[3]), 64'h2);
        chk("rf_idx0_untouched",  64'(rf_dut[0]), 64'h0);
        chk("rf_idx9_discarded",  64'(rf_dut[9]), 64'h0);

        // Continuous req0_valid: one write per two cycles, in order
        wr_q.delete();
        for (int c = 0; c < 20; c++)
            step(0, 1, AW'(1 + c % 30), DW'(32'h100 + c), 0, '0, '0);
        step(0, 0, '0, '0, 0, '0, '0);
        step(0, 0, '0, '0, 0, '0, '0);
        nwr = wr_q.size();
        chk("stream_write_count", 64'(nwr), 64'd10);
        for (int k = 0; k < 10; k++) begin
            ex = 32'h100 + 2 * k;
            if (k < nwr) chk($sformatf("stream_data%0d", k), 64'(wr_q[k]), 64'(ex));
            else         chk($sformatf("stream_data%0d", k), 64'hDEAD, 64'(ex));
        end

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            logic [AW-1:0] ri0, ri1;
            ri0 = ($urandom_range(0, 9) == 0) ? AW'(0) : AW'($urandom_range(1, 31));
            ri1 = ($urandom_range(0, 9) == 0) ? AW'(0) : AW'($urandom_range(1, 31));
            step($urandom_range(0, 59) == 0,
                 $urandom_range(0, 1) == 1, ri0, DW'($urandom),
                 $urandom_range(0, 2) != 0, ri1, DW'($urandom));
        end
        step(0, 0, '0, '0, 0, '0, '0);
        step(0, 0, '0, '0, 0, '0, '0);
        step(0, 0, '0, '0, 0, '0, '0);
        for (int i = 0; i < 32; i++)
            chk($sformatf("rf_final%0d", i), 64'(rf_dut[i]), 64'(rf_mod[i]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
